// File: rtl/xdom_pkg.sv
// rtl/xdom_pkg.sv - address map, readout state encoding and word helpers for xdom_chan_ctrl
package xdom_pkg;

  localparam logic [11:0] ADR_TRIG  = 12'hE00;
  localparam logic [11:0] ADR_ARM   = 12'hE10;
  localparam logic [11:0] ADR_WRST  = 12'hE20;
  localparam logic [11:0] ADR_ARMED = 12'hE30;
  localparam logic [11:0] ADR_OVF   = 12'hE40;
  localparam logic [11:0] ADR_HFULL = 12'hE50;
  localparam logic [11:0] ADR_SEL   = 12'hE60;
  localparam logic [11:0] ADR_NWFMS = 12'hE61;
  localparam logic [11:0] ADR_WDS   = 12'hE62;
  localparam logic [11:0] ADR_RLEN  = 12'hE63;
  localparam logic [11:0] ADR_RSTAT = 12'hE64;
  localparam logic [11:0] ADR_NCH   = 12'hE65;
  localparam logic [11:0] ADR_SNAP  = 12'hE66;

  typedef enum logic [1:0] {
    RD_IDLE    = 2'd0,
    RD_BUSY    = 2'd1,
    RD_TIMEOUT = 2'd2
  } rd_state_e;

  // Per-channel vectors are zero-extended to 64 bits so channels past the top read 0.
  function automatic logic [15:0] word_of(input logic [63:0] vec, input logic [1:0] w);
    return vec[{w, 4'b0000} +: 16];
  endfunction

  function automatic logic word_hit(input logic [11:0] adr, input logic [7:0] page,
                                    input logic [3:0] nw);
    return (adr[11:4] == page) && (adr[3:0] < nw);
  endfunction

endpackage

// File: rtl/xdom_pulse_group.sv
// rtl/xdom_pulse_group.sv - one-shot channel mask with a shared retriggerable width counter
module xdom_pulse_group
  import xdom_pkg::*;
#(
  parameter int N_CHANNELS = 24,
  parameter int PULSE_LEN  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [1:0]            sel_word,
  input  logic [15:0]           wr_data,
  output logic [N_CHANNELS-1:0] pulse
);

  logic [N_CHANNELS-1:0] mask_q;
  logic [N_CHANNELS-1:0] set_bits;
  logic [3:0]            cnt_q;

  always_comb begin
    set_bits = '0;
    for (int c = 0; c < N_CHANNELS; c++) begin
      if (sel_word == 2'(c / 16)) set_bits[c] = wr_data[c % 16];
    end
  end

  // A new write extends the whole group's pulse, including bits set earlier.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
      cnt_q  <= '0;
    end else if (wr) begin
      mask_q <= mask_q | set_bits;
      cnt_q  <= 4'(PULSE_LEN);
    end else if (cnt_q == 4'd1) begin
      mask_q <= '0;
      cnt_q  <= '0;
    end else if (cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign pulse = mask_q;

endmodule

// File: rtl/xdom_chan_ctrl.sv
// rtl/xdom_chan_ctrl.sv - CRS register block for per-channel waveform buffer control and readout handshake
module xdom_chan_ctrl
  import xdom_pkg::*;
#(
  parameter int N_CHANNELS   = 24,
  parameter int PULSE_LEN    = 1,
  parameter int TIMEOUT_BITS = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [11:0]              y_adr,
  input  logic [15:0]              y_wr_data,
  input  logic                     y_wr,
  output logic [15:0]              y_rd_data,
  output logic                     y_hit,
  output logic [N_CHANNELS-1:0]    trig_run,
  output logic [N_CHANNELS-1:0]    wvb_arm,
  output logic [N_CHANNELS-1:0]    wvb_rst,
  input  logic [N_CHANNELS-1:0]    wvb_armed,
  input  logic [N_CHANNELS-1:0]    wvb_overflow,
  input  logic [N_CHANNELS-1:0]    wvb_hdr_full,
  input  logic [N_CHANNELS*16-1:0] wfms_in_buf,
  input  logic [N_CHANNELS*16-1:0] buf_wds_used,
  input  logic                     rdout_run,
  input  logic [15:0]              rdout_len,
  output logic                     rdout_busy,
  output logic                     rdout_timeout
);

  localparam int NW = (N_CHANNELS + 15) / 16;
  localparam logic [3:0] NW4 = 4'(NW);

  logic hit_trig, hit_arm, hit_wrst, hit_armed, hit_ovf, hit_hfull;
  logic done;

  assign hit_trig  = word_hit(y_adr, ADR_TRIG[11:4], NW4);
  assign hit_arm   = word_hit(y_adr, ADR_ARM[11:4], NW4);
  assign hit_wrst  = word_hit(y_adr, ADR_WRST[11:4], NW4);
  assign hit_armed = word_hit(y_adr, ADR_ARMED[11:4], NW4);
  assign hit_ovf   = word_hit(y_adr, ADR_OVF[11:4], NW4);
  assign hit_hfull = word_hit(y_adr, ADR_HFULL[11:4], NW4);
  assign done      = y_wr && (y_adr == ADR_RLEN) && y_wr_data[0];

  xdom_pulse_group #(.N_CHANNELS(N_CHANNELS), .PULSE_LEN(PULSE_LEN)) u_trig (
    .clk(clk), .rst(rst), .wr(y_wr && hit_trig), .sel_word(y_adr[1:0]),
    .wr_data(y_wr_data), .pulse(trig_run)
  );

  xdom_pulse_group #(.N_CHANNELS(N_CHANNELS), .PULSE_LEN(PULSE_LEN)) u_arm (
    .clk(clk), .rst(rst), .wr(y_wr && hit_arm), .sel_word(y_adr[1:0]),
    .wr_data(y_wr_data), .pulse(wvb_arm)
  );

  logic [N_CHANNELS-1:0] wvb_rst_q, wrst_d;
  logic [N_CHANNELS-1:0] snap_armed_q, snap_ovf_q, snap_hfull_q;
  logic [5:0]            sel_q;
  logic [15:0]           n_wfms_q, wds_q, sel_wfms, sel_wds;

  always_comb begin
    wrst_d   = wvb_rst_q;
    sel_wfms = '0;
    sel_wds  = '0;
    for (int c = 0; c < N_CHANNELS; c++) begin
      if (y_adr[1:0] == 2'(c / 16)) wrst_d[c] = y_wr_data[c % 16];
      if (sel_q == 6'(c)) begin
        sel_wfms = wfms_in_buf[c*16 +: 16];
        sel_wds  = buf_wds_used[c*16 +: 16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wvb_rst_q    <= '0;
      snap_armed_q <= '0;
      snap_ovf_q   <= '0;
      snap_hfull_q <= '0;
      sel_q        <= '0;
      n_wfms_q     <= '0;
      wds_q        <= '0;
    end else begin
      if (y_wr && hit_wrst) wvb_rst_q <= wrst_d;
      if (y_wr && (y_adr == ADR_SNAP)) begin
        snap_armed_q <= wvb_armed;
        snap_ovf_q   <= wvb_overflow;
        snap_hfull_q <= wvb_hdr_full;
      end
      if (y_wr && (y_adr == ADR_SEL)) sel_q <= y_wr_data[5:0];
      n_wfms_q <= sel_wfms;
      wds_q    <= sel_wds;
    end
  end

  assign wvb_rst = wvb_rst_q;

  rd_state_e               state_q, state_d;
  logic [TIMEOUT_BITS-1:0] cnt_q, cnt_d;
  logic [15:0]             len_q, len_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RD_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // A done write beats a coincident rdout_run in every state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if (done) begin
      state_d = RD_IDLE;
      len_d   = '0;
    end else begin
      case (state_q)
        RD_IDLE: begin
          if (rdout_run) begin
            state_d = RD_BUSY;
            len_d   = rdout_len;
            cnt_d   = '0;
          end
        end
        RD_BUSY: begin
          cnt_d = cnt_q + TIMEOUT_BITS'(1);
          if (cnt_d == '1) state_d = RD_TIMEOUT;
        end
        default: ;
      endcase
    end
  end

  assign rdout_busy    = (state_q != RD_IDLE);
  assign rdout_timeout = (state_q == RD_TIMEOUT);

  always_comb begin
    y_hit     = 1'b0;
    y_rd_data = '0;
    if (hit_trig || hit_arm) begin
      y_hit = 1'b1;
    end else if (hit_wrst) begin
      y_hit     = 1'b1;
      y_rd_data = word_of(64'(wvb_rst_q), y_adr[1:0]);
    end else if (hit_armed) begin
      y_hit     = 1'b1;
      y_rd_data = word_of(64'(snap_armed_q), y_adr[1:0]);
    end else if (hit_ovf) begin
      y_hit     = 1'b1;
      y_rd_data = word_of(64'(snap_ovf_q), y_adr[1:0]);
    end else if (hit_hfull) begin
      y_hit     = 1'b1;
      y_rd_data = word_of(64'(snap_hfull_q), y_adr[1:0]);
    end else begin
      case (y_adr)
        ADR_SEL:   begin y_hit = 1'b1; y_rd_data = {10'b0, sel_q}; end
        ADR_NWFMS: begin y_hit = 1'b1; y_rd_data = n_wfms_q; end
        ADR_WDS:   begin y_hit = 1'b1; y_rd_data = wds_q; end
        ADR_RLEN:  begin y_hit = 1'b1; y_rd_data = len_q; end
        ADR_RSTAT: begin y_hit = 1'b1; y_rd_data = {14'b0, rdout_timeout, rdout_busy}; end
        ADR_NCH:   begin y_hit = 1'b1; y_rd_data = 16'(N_CHANNELS); end
        ADR_SNAP:  y_hit = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/xdom_chan_ctrl.md
XDOM_CHAN_CTRL -- requirements
Module: xdom_chan_ctrl

Interface
REQ-001 The module SHALL have parameter N_CHANNELS, default 24, meaning the channel count, legal range 1..64.
REQ-002 The module SHALL have parameter PULSE_LEN, default 1, meaning the one-shot width in clk cycles, legal range 1..15.
REQ-003 The module SHALL have parameter TIMEOUT_BITS, default 24, meaning the readout timeout counter width, legal range 4..32.
REQ-004 The module SHALL derive local constant NW = ceil(N_CHANNELS/16), meaning the number of 16-bit words per channel vector.
REQ-005 The module SHALL have port clk, input, 1 bit: clock.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 The module SHALL have port y_adr, input, 12 bits: CRS register address.
REQ-008 The module SHALL have port y_wr_data, input, 16 bits: CRS write data.
REQ-009 The module SHALL have port y_wr, input, 1 bit: CRS write strobe, valid for one cycle.
REQ-010 The module SHALL have port y_rd_data, output, 16 bits: combinational read data for y_adr.
REQ-011 The module SHALL have port y_hit, output, 1 bit: combinational; 1 when y_adr decodes to a register of this block.
REQ-012 The module SHALL have ports trig_run, wvb_arm and wvb_rst, each output, N_CHANNELS bits: per-channel controls.
REQ-013 The module SHALL have ports wvb_armed, wvb_overflow and wvb_hdr_full, each input, N_CHANNELS bits: per-channel status.
REQ-014 The module SHALL have ports wfms_in_buf and buf_wds_used, each input, N_CHANNELS*16 bits: per-channel counts, with channel c at bits [16c+15:16c].
REQ-015 The module SHALL have ports rdout_run, input, 1 bit, and rdout_len, input, 16 bits: readout start pulse and readout length.
REQ-016 The module SHALL have ports rdout_busy and rdout_timeout, each output, 1 bit: readout handshake status.

Function
REQ-017 The address map SHALL be as follows; w denotes a word index, 0 <= w < NW; all other addresses SHALL drive y_hit=0 and y_rd_data=0.
- 0xE00+w: trig_run pulse word, write-only, reads 0.
- 0xE10+w: wvb_arm pulse word, write-only, reads 0.
- 0xE20+w: wvb_rst level word, read/write.
- 0xE30+w, 0xE40+w, 0xE50+w: armed, overflow and hdr_full snapshot words, read-only.
- 0xE60: status channel select, read/write, bits [5:0].
- 0xE61: n_wfms, read-only.
- 0xE62: wds_used, read-only.
- 0xE63: readout length; read returns it, write with bit0=1 means done.
- 0xE64: {14'b0, timeout, busy}, read-only.
- 0xE65: N_CHANNELS constant, read-only.
- 0xE66: snapshot strobe, write-only.
REQ-018 Word w SHALL map to channels 16w..16w+15; bits at or above N_CHANNELS SHALL be ignored on write and SHALL read 0.
REQ-019 A pulse-word write SHALL OR its bits into that group's active mask one cycle after y_wr and restart the group's shared counter; the outputs SHALL stay high for exactly PULSE_LEN cycles after the last write, then clear.
REQ-020 A wvb_rst word write SHALL update only that word's channels, registered one cycle after y_wr.
REQ-021 A write to 0xE66 SHALL capture all three status vectors in the cycle after y_wr; snapshot reads SHALL return only the captured values.
REQ-022 Every cycle, the n_wfms and wds_used registers SHALL load the selected channel's counts, giving 1-cycle latency; a select >= N_CHANNELS SHALL load 0.
REQ-023 The readout FSM SHALL have states IDLE, BUSY and TIMEOUT.
- IDLE -> BUSY on rdout_run; latch rdout_len; clear the counter.
- BUSY: increment the counter; -> TIMEOUT when the counter reaches all-ones.
- BUSY or TIMEOUT -> IDLE on a done write; clear the length.
REQ-024 rdout_busy SHALL be 1 in BUSY and TIMEOUT; rdout_timeout SHALL be 1 only in TIMEOUT.
REQ-025 rdout_run in BUSY or TIMEOUT SHALL be ignored with no relatch; if rdout_run and a done write coincide, done SHALL win and the FSM SHALL enter IDLE.

Reset
REQ-026 rst SHALL clear all outputs, masks, counters, snapshots, the select and the length, and SHALL force IDLE; rst mid-pulse SHALL drop the pulses in the next cycle.
REQ-027 rst SHALL have priority over y_wr and rdout_run in the same cycle.

Structure
REQ-028 Package xdom_pkg SHALL hold the address constants and the FSM state encoding.
REQ-029 The design SHALL use one sub-module, xdom_pulse_group, instantiated twice, for the mask and counter; the FSM and decode SHALL be inline.

Verification
REQ-030 The bench SHALL use N_CHANNELS=24, PULSE_LEN=3 and TIMEOUT_BITS=4, and SHALL cover:
- Write 0x0005 to 0xE00 -> trig_run=0x000005 for exactly 3 cycles, starting the cycle after y_wr.
- Write 0xFFFF to 0xE11 -> wvb_arm[23:16]=0xFF; a read of 0xE21 returns 0; a wvb_rst write of 0xFFFF to 0xE21 reads back 0x00FF.
- Set wvb_overflow=0x800001, write 0xE66, then set wvb_overflow=0 -> 0xE40 reads 0x0001 and 0xE41 reads 0x0080.
- Select 5 with wfms_in_buf ch5=0x1234 -> 0xE61 reads 0x1234; select 30 -> 0xE61 reads 0.
- rdout_run with len=0x0200 -> 0xE64 reads 1 and 0xE63 reads 0x0200; after 15 cycles 0xE64 reads 3; a done write -> 0xE64 reads 0 and 0xE63 reads 0.
- rdout_run and a done write in the same cycle while BUSY -> IDLE, no relatch; rst during a pulse -> outputs 0 in the next cycle.
